// File: rtl/cello_probe_pkg.sv
// Shared types and constants for the 3-input gate truth-table prober.
package cello_probe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        REPORT
    } state_e;

    localparam int N_IN   = 3;
    localparam int N_ROWS = 8;
    localparam int ID_W   = 8;

    // Row 000 lands in the MSB, row 111 in the LSB, matching the gate naming.
    function automatic logic [N_IN-1:0] row_bit(input logic [N_IN-1:0] row);
        return N_IN'(N_ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/truth_table_prober_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/truth_table_prober.sv
// Sweeps all eight input rows into a 3-input gate, samples its output after a
// settle time and assembles the recovered 8-bit truth-table ID.
//
//   state  | meaning
//   IDLE   | waiting for start, probe_in parked at 000
//   SWEEP  | holding one row for SETTLE cycles, sampling on the last
//   REPORT | one cycle: publish match and pulse valid
module truth_table_prober
    import cello_probe_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ID_W-1:0] expected,
    input  logic            dut_out,
    output logic [N_IN-1:0] probe_in,
    output logic            busy,
    output logic            valid,
    output logic [ID_W-1:0] table_id,
    output logic            match
);

    generate
        if (SETTLE < 3 || SETTLE > 255) begin : g_bad_settle
            $error("truth_table_prober: SETTLE must be within 3..255");
        end
    endgenerate

    localparam logic [7:0]      RELOAD   = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(N_ROWS - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] row_q, row_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] probe_q, probe_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            match_q, match_d;
    logic [ID_W-1:0] exp_q, exp_d;
    logic            sampled;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (sampled)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        probe_d = probe_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        id_d    = id_q;
        match_d = match_q;
        exp_d   = exp_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    row_d   = '0;
                    probe_d = '0;
                    cnt_d   = RELOAD;
                    exp_d   = expected;
                    id_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    id_d[row_bit(row_q)] = sampled;
                    if (row_q != LAST_ROW) begin
                        row_d   = row_q + 1'b1;
                        probe_d = row_q + 1'b1;
                        cnt_d   = RELOAD;
                    end else begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                valid_d = 1'b1;
                match_d = (id_q == exp_q);
                probe_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            probe_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= '0;
            match_q <= 1'b0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            probe_q <= probe_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            match_q <= match_d;
            exp_q   <= exp_d;
        end
    end

    assign probe_in = probe_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign table_id = id_q;
    assign match    = match_q;

endmodule

// File: tb/tb_truth_table_prober.sv
// Randomized and directed checks of truth_table_prober against a row-by-row gate model.
module tb_truth_table_prober;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       dut_out;
    logic [2:0] probe_in;
    logic       busy, valid, match;
    logic [7:0] table_id;

    int total = 0;
    int bad = 0;
    int vcount = 0;
    int cyc = 0;
    int mode = 0;
    logic [7:0] rand_tbl = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (valid) vcount++;
    end

    // Gate behaviour by mode; mode 5 is an arbitrary table where rand_tbl[r] is row r's output.
    function automatic logic gate_eval(input int m, input logic [2:0] r, input logic [7:0] tbl);
        logic i1, i2, i3;
        i1 = r[2];
        i2 = r[1];
        i3 = r[0];
        case (m)
            0:       return i1 ^ (i2 & i3);
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~i3;
            4:       return i1 & i2 & i3;
            default: return tbl[r];
        endcase
    endfunction

    function automatic logic [7:0] model_id(input int m, input logic [7:0] tbl);
        int id;
        id = 0;
        for (int r = 0; r < 8; r++)
            if (gate_eval(m, 3'(r), tbl)) id = id + (1 << (7 - r));
        return 8'(id);
    endfunction

    assign dut_out = gate_eval(mode, probe_in, rand_tbl);

    truth_table_prober #(.SETTLE(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .expected (expected),
        .dut_out  (dut_out),
        .probe_in (probe_in),
        .busy     (busy),
        .valid    (valid),
        .table_id (table_id),
        .match    (match)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic sweep(input int m, input logic [7:0] exp_id, input int restart_at, input bit chk_probe);
        int lat;
        int v0;
        logic [7:0] ref_id;
        mode = m;
        expected = exp_id;
        ref_id = model_id(m, rand_tbl);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        expected = 8'($urandom);
        v0 = vcount;
        lat = 0;
        chk("busy_on", busy, 1);
        if (chk_probe) chk("probe_row", probe_in, 0);
        while (!valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == restart_at);
            if (chk_probe && lat < 8 * S) chk("probe_row", probe_in, lat / S);
        end
        start = 1'b0;
        chk("latency", lat, 8 * S + 1);
        chk("table_id", table_id, ref_id);
        chk("match", match, (ref_id == exp_id));
        chk("busy_off", busy, 0);
        chk("probe_idle", probe_in, 0);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", valid, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("valid_pulses", vcount - v0, 1);
    endtask

    initial begin
        int t1, t2, v0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_probe", probe_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_table_id", table_id, 0);
        chk("rst_match", match, 0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep(0, 8'h1E, -1, 1'b1);
        chk("xor_and_id", table_id, 8'h1E);
        sweep(1, 8'h1E, -1, 1'b0);
        chk("zero_id", table_id, 8'h00);
        sweep(2, 8'hFF, -1, 1'b0);
        chk("one_id", table_id, 8'hFF);
        sweep(3, 8'hAA, 10, 1'b0);
        chk("not_in3_id", table_id, 8'hAA);

        // Reset in the middle of a sweep
        mode = 0;
        expected = 8'h1E;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_probe", probe_in, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_table_id", table_id, 0);
        chk("midrst_match", match, 0);
        v0 = vcount;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("midrst_no_valid", vcount - v0, 0);
        sweep(0, 8'h1E, -1, 1'b0);

        // start held high across two sweeps
        mode = 4;
        expected = 8'h01;
        t1 = -1;
        t2 = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 120 && t2 < 0; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
                chk("held_id", table_id, 8'h01);
                chk("held_match", match, 1);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_gap", t2 - t1, 34);
        repeat (40) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            rand_tbl = 8'($urandom);
            if ($urandom_range(0, 1) == 1) sweep(5, model_id(5, rand_tbl), -1, 1'b0);
            else sweep(5, 8'($urandom), -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
